// File: rtl/ibex_rf_bank_sched_if.sv
// ibex_rf_bank_sched_if
//   Request/grant/rvalid bus between the register-file access scheduler and
//   the slow single-ported register bank.
//   master : scheduler side (drives request, write flag, address, write data)
//   slave  : bank side (drives grant, read-valid, read data)
//   Only one transaction is ever outstanding: a read is granted first and
//   its data returns on bank_rvalid_i at least one cycle after the grant.
interface ibex_rf_bank_sched_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 bank_req_o;
  logic                 bank_we_o;
  logic [4:0]           bank_addr_o;
  logic [DataWidth-1:0] bank_wdata_o;
  logic                 bank_gnt_i;
  logic                 bank_rvalid_i;
  logic [DataWidth-1:0] bank_rdata_i;

  modport master (
    output bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o,
    input  bank_gnt_i, bank_rvalid_i, bank_rdata_i
  );

  modport slave (
    input  bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o,
    output bank_gnt_i, bank_rvalid_i, bank_rdata_i
  );
endinterface

// File: rtl/ibex_rf_bank_sched.sv
// ibex_rf_bank_sched
//   Access scheduler for the two-level register file. x[FastLo..FastHi] live
//   in a fast multi-ported bank and are served in the same cycle; all other
//   non-zero registers live in a slow single-ported bank reached through
//   ibex_rf_bank_sched_if. Slow work for one bundle runs in the fixed order
//   WRITE, READ_A, READ_B while stall_o holds the ID stage; the DONE cycle
//   then presents the final operands.
//
//   Ports
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     acc_valid_i                   bundle valid (held stable while stalled)
//     raddr_a_i, raddr_b_i          read addresses
//     waddr_i, wdata_i, we_i        write port
//     stall_o                       slow access pending, ID must hold
//     rdata_a_o, rdata_b_o          final operands (acc_valid_i & !stall_o)
//     fast_we_o                     fast-bank write strobe
//     fast_rdata_a_i/_b_i           fast-bank read data
//     bank                          slow-bank bus (master modport)
//     perf_stall_cnt_o              cycles with stall_o=1
//     perf_access_cnt_o             slow-bank grants
//
//   Build option: RF_BANK_SCHED_PERF_EN builds the two saturating
//   performance counters; without it both outputs are tied to zero.

// Address classifier, one instance per register address of the bundle.
module ibex_rf_bank_sched_cls #(
  parameter bit          RV32E  = 1'b0,
  parameter int unsigned FastLo = 12,
  parameter int unsigned FastHi = 15
) (
  input  logic [4:0] addr_i,
  output logic       zero_o,
  output logic       fast_o
);
  localparam logic [4:0] Lo = 5'(FastLo);
  localparam logic [4:0] Hi = 5'(FastHi);

  // In RV32E mode x16..x31 do not exist and behave like x0.
  assign zero_o = (addr_i == 5'd0) | (RV32E & addr_i[4]);
  assign fast_o = ~zero_o & (addr_i >= Lo) & (addr_i <= Hi);
endmodule

module ibex_rf_bank_sched #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned FastLo    = 12,
  parameter int unsigned FastHi    = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 acc_valid_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 we_i,
  output logic                 stall_o,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 fast_we_o,
  input  logic [DataWidth-1:0] fast_rdata_a_i,
  input  logic [DataWidth-1:0] fast_rdata_b_i,
  ibex_rf_bank_sched_if.master bank,
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_access_cnt_o
);
  // Read ports are lanes 0..NumPorts-1; lane NumPorts is the write address.
  localparam int unsigned NumPorts = 2;
  localparam int unsigned WIdx     = NumPorts;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RA, S_RA_W, S_RB, S_RB_W, S_DONE
  } state_e;

  state_e state_q, state_d, cur_st, first_st, after_w, after_a;

  logic [NumPorts:0][4:0]             addr;
  logic [NumPorts:0]                  is_zero, is_fast, is_slow;
  logic [NumPorts-1:0]                fwd;
  logic [NumPorts-1:0][DataWidth-1:0] fast_rdata, rdata, cap_q;
  logic                               need_w, need_a, need_b, share;
  logic                               req_c, we_c, stall_c;
  logic [4:0]                         addr_c;

  assign addr       = {waddr_i, raddr_b_i, raddr_a_i};
  assign fast_rdata = {fast_rdata_b_i, fast_rdata_a_i};

  for (genvar g = 0; g <= NumPorts; g++) begin : g_cls
    ibex_rf_bank_sched_cls #(
      .RV32E (RV32E),
      .FastLo(FastLo),
      .FastHi(FastHi)
    ) u_cls (
      .addr_i(addr[g]),
      .zero_o(is_zero[g]),
      .fast_o(is_fast[g])
    );
    assign is_slow[g] = ~is_zero[g] & ~is_fast[g];
  end

  // Operand mux per read port: zero, then forwarded write data, then fast
  // bank, then the value captured from the slow bank.
  for (genvar g = 0; g < NumPorts; g++) begin : g_rport
    assign fwd[g]   = we_i & ~is_zero[WIdx] & (addr[g] == waddr_i);
    assign rdata[g] = is_zero[g] ? '0 :
                      fwd[g]     ? wdata_i :
                      is_fast[g] ? fast_rdata[g] : cap_q[g];
  end

  assign rdata_a_o = rdata[0];
  assign rdata_b_o = rdata[1];

  // Slow work of the current bundle. Identical slow reads share one access.
  assign need_w = we_i & is_slow[WIdx];
  assign need_a = is_slow[0] & ~fwd[0];
  assign share  = need_a & (raddr_a_i == raddr_b_i);
  assign need_b = is_slow[1] & ~fwd[1] & ~share;

  // IDLE issues the first slow op combinationally in the same cycle the
  // bundle arrives, so cur_st is the state whose request is on the bus now.
  always_comb begin
    first_st = S_IDLE;
    if (need_b) first_st = S_RB;
    if (need_a) first_st = S_RA;
    if (need_w) first_st = S_WR;
    after_w = need_a ? S_RA : (need_b ? S_RB : S_DONE);
    after_a = need_b ? S_RB : S_DONE;
    cur_st  = (state_q == S_IDLE && acc_valid_i) ? first_st : state_q;
  end

  always_comb begin
    state_d = cur_st;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    unique case (cur_st)
      S_WR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = waddr_i;
        if (bank.bank_gnt_i) state_d = after_w;
      end
      S_RA: begin
        req_c  = 1'b1;
        addr_c = raddr_a_i;
        if (bank.bank_gnt_i) state_d = S_RA_W;
      end
      S_RA_W: if (bank.bank_rvalid_i) state_d = after_a;
      S_RB: begin
        req_c  = 1'b1;
        addr_c = raddr_b_i;
        if (bank.bank_gnt_i) state_d = S_RB_W;
      end
      S_RB_W: if (bank.bank_rvalid_i) state_d = S_DONE;
      default: state_d = S_IDLE;   // S_IDLE with nothing slow, and S_DONE
    endcase
  end

  assign stall_c = (cur_st != S_IDLE) && (cur_st != S_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Read data is taken only in the matching wait state; a stray rvalid
  // anywhere else is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q <= '0;
    end else if (bank.bank_rvalid_i) begin
      if (state_q == S_RA_W) begin
        cap_q[0] <= bank.bank_rdata_i;
        if (share) cap_q[1] <= bank.bank_rdata_i;
      end else if (state_q == S_RB_W) begin
        cap_q[1] <= bank.bank_rdata_i;
      end
    end
  end

  // The request path is combinational from the held bundle, so outputs are
  // qualified with rst_ni: a reset pulls request and stall low at once even
  // while acc_valid_i is still asserted.
  assign stall_o           = rst_ni & stall_c;
  assign bank.bank_req_o   = rst_ni & req_c;
  assign bank.bank_we_o    = rst_ni & req_c & we_c;
  assign bank.bank_addr_o  = (rst_ni & req_c) ? addr_c : '0;
  assign bank.bank_wdata_o = (rst_ni & req_c & we_c) ? wdata_i : '0;
  assign fast_we_o         = rst_ni & acc_valid_i & we_i & is_fast[WIdx] &
                             (state_q == S_IDLE);

`ifdef RF_BANK_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, access_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      if (stall_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (req_c && bank.bank_gnt_i && access_cnt_q != '1)
        access_cnt_q <= access_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o  = stall_cnt_q;
  assign perf_access_cnt_o = access_cnt_q;
`else
  assign perf_stall_cnt_o  = '0;
  assign perf_access_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ibex_rf_bank_sched.sv
// Bench for ibex_rf_bank_sched: directed bundles against a bank responder
// with programmable grant/rvalid latency and an abstract per-bundle model
// (list of slow ops, total stall cycles, final operand values).
module tb_ibex_rf_bank_sched;
  logic        clk = 1'b0, rst_ni = 1'b0, acc_valid = 1'b0, we = 1'b0;
  logic [4:0]  ra = '0, rb = '0, wa = '0;
  logic [31:0] wd = '0, fa = '0, fb = '0;
  logic        stall, fwe;
  logic [31:0] rda, rdb, pst, pac;

  ibex_rf_bank_sched_if #(.DataWidth(32)) bif ();

  ibex_rf_bank_sched dut (
    .clk_i(clk), .rst_ni(rst_ni), .acc_valid_i(acc_valid),
    .raddr_a_i(ra), .raddr_b_i(rb), .waddr_i(wa), .wdata_i(wd), .we_i(we),
    .stall_o(stall), .rdata_a_o(rda), .rdata_b_o(rdb), .fast_we_o(fwe),
    .fast_rdata_a_i(fa), .fast_rdata_b_i(fb), .bank(bif.master),
    .perf_stall_cnt_o(pst), .perf_access_cnt_o(pac)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [4:0] addr; logic [31:0] data; } op_t;

  int          n_cmp = 0, n_bad = 0;
  op_t         exp_ops[$];
  logic [31:0] mem [32];
  int          gd = 0, rvd = 1, wcnt = 0, rvleft = 0;
  logic [31:0] pend = '0;
  bit          active = 0, done = 0, first = 0, exp_fwe = 0;
  int          exp_left = 0, obs_stall = 0, tot_stall = 0, tot_acc = 0;
  logic [31:0] exp_a = '0, exp_b = '0, obs_a = '0, obs_b = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic bit m_zero(input logic [4:0] a); return a == 5'd0; endfunction
  function automatic bit m_fast(input logic [4:0] a); return a >= 5'd12 && a <= 5'd15; endfunction
  function automatic bit m_slow(input logic [4:0] a); return !m_zero(a) && !m_fast(a); endfunction

  // Slow bank: grant after gd waiting cycles, read data gd..rvd cycles later.
  always begin
    @(posedge clk); #2;
    bif.bank_gnt_i    = 1'b0;
    bif.bank_rvalid_i = 1'b0;
    bif.bank_rdata_i  = 32'hDEAD_BEEF;
    if (!rst_ni) begin
      wcnt = 0; rvleft = 0;
    end else begin
      if (rvleft > 0) begin
        rvleft--;
        if (rvleft == 0) begin bif.bank_rvalid_i = 1'b1; bif.bank_rdata_i = pend; end
      end
      if (bif.bank_req_o) begin
        if (wcnt >= gd) begin
          bif.bank_gnt_i = 1'b1;
          wcnt = 0;
          if (bif.bank_we_o) mem[bif.bank_addr_o] = bif.bank_wdata_o;
          else begin pend = mem[bif.bank_addr_o]; rvleft = rvd; end
        end else wcnt++;
      end
    end
  end

  // Single compare process: bus ops in order, stall window, final operands.
  always @(negedge clk) begin
    if (active && rst_ni) begin
      if (exp_ops.size() == 0) chk("idle_req", bif.bank_req_o, 1'b0);
      else if (bif.bank_req_o) begin
        chk("bank_we", bif.bank_we_o, exp_ops[0].we);
        chk("bank_addr", bif.bank_addr_o, exp_ops[0].addr);
        if (exp_ops[0].we) chk("bank_wdata", bif.bank_wdata_o, exp_ops[0].data);
        if (bif.bank_gnt_i) void'(exp_ops.pop_front());
      end
      chk("fast_we", fwe, first & exp_fwe);
      first = 0;
      if (exp_left > 0) begin
        chk("stall_hi", stall, 1'b1);
        obs_stall += int'(stall);
        exp_left--;
      end else begin
        chk("stall_lo", stall, 1'b0);
        chk("rdata_a", rda, exp_a);
        chk("rdata_b", rdb, exp_b);
        chk("ops_left", exp_ops.size(), 0);
        obs_a = rda; obs_b = rdb;
        done = 1; active = 0;
      end
    end
  end

  task automatic bundle(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                        input logic [31:0] d, input bit e, input logic [31:0] xa,
                        input logic [31:0] xb, input int g, input int r);
    bit fwa, fwb, sa, sb;
    int cost;
    op_t op;
    @(posedge clk); #1;
    cost = 0;
    fwa = e && !m_zero(w) && a == w;
    fwb = e && !m_zero(w) && b == w;
    exp_a = m_zero(a) ? 32'h0 : fwa ? d : m_fast(a) ? xa : mem[a];
    exp_b = m_zero(b) ? 32'h0 : fwb ? d : m_fast(b) ? xb : mem[b];
    exp_ops.delete();
    if (e && m_slow(w)) begin
      op.we = 1; op.addr = w; op.data = d; exp_ops.push_back(op); cost += g + 1;
    end
    sa = m_slow(a) && !fwa;
    sb = m_slow(b) && !fwb && !(sa && a == b);
    if (sa) begin op.we = 0; op.addr = a; op.data = 0; exp_ops.push_back(op); cost += g + 1 + r; end
    if (sb) begin op.we = 0; op.addr = b; op.data = 0; exp_ops.push_back(op); cost += g + 1 + r; end
    exp_fwe = e && m_fast(w);
    tot_stall += cost;
    tot_acc   += exp_ops.size();
    ra = a; rb = b; wa = w; wd = d; we = e; fa = xa; fb = xb; acc_valid = 1'b1;
    gd = g; rvd = r; wcnt = 0;
    exp_left = cost; obs_stall = 0; done = 0; first = 1; active = 1;
    for (int i = 0; i < 300 && !done; i++) @(posedge clk);
    if (!done) begin chk("timeout", done, 1'b1); active = 0; end
    #1 acc_valid = 1'b0; we = 1'b0;
  endtask

  task automatic chk_perf(input string nm);
`ifdef RF_BANK_SCHED_PERF_EN
    chk({nm, "_stall_cnt"}, pst, tot_stall);
    chk({nm, "_access_cnt"}, pac, tot_acc);
`else
    chk({nm, "_stall_cnt"}, pst, 0);
    chk({nm, "_access_cnt"}, pac, 0);
`endif
  endtask

  initial begin
    op_t op;
    bif.bank_gnt_i = 1'b0; bif.bank_rvalid_i = 1'b0; bif.bank_rdata_i = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
    mem[5] = 32'h1234;
    mem[9] = 32'h9999_0009;

    // Reset with a slow bundle already presented: everything held low.
    acc_valid = 1'b1; ra = 5'd5;
    #3;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", bif.bank_req_o, 1'b0);
    chk("rst_we", bif.bank_we_o, 1'b0);
    chk("rst_addr", bif.bank_addr_o, 0);
    chk("rst_wdata", bif.bank_wdata_o, 0);
    chk("rst_fast_we", fwe, 1'b0);
    chk_perf("rst");
    #20;
    @(negedge clk); acc_valid = 1'b0; ra = '0; rst_ni = 1'b1;

    // Fast read, zero latency.
    bundle(5'd12, 5'd0, 5'd0, 32'h0, 0, 32'hA5A5, 32'h0, 0, 1);
    chk("t1_rdata_a", obs_a, 32'hA5A5);
    chk("t1_rdata_b", obs_b, 32'h0);
    chk("t1_stall_cycles", obs_stall, 0);

    // Write + two distinct slow reads, zero-wait bank.
    bundle(5'd3, 5'd17, 5'd8, 32'h0808_0808, 1, 32'h0, 32'h0, 0, 1);
    chk("t5_stall_cycles", obs_stall, 5);
`ifdef RF_BANK_SCHED_PERF_EN
    chk("t5_perf_stall", pst, 5);
    chk("t5_perf_access", pac, 3);
`endif

    // Single slow read, immediate grant, rvalid next cycle.
    bundle(5'd5, 5'd0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    chk("t2_rdata_a", obs_a, 32'h1234);
    chk("t2_stall_cycles", obs_stall, 2);

    // Slow write forwarded to port A, port B reads x20.
    bundle(5'd7, 5'd20, 5'd7, 32'hBEEF, 1, 32'h0, 32'h0, 0, 1);
    chk("t3_rdata_a", obs_a, 32'hBEEF);
    chk("t3_rdata_b", obs_b, 32'h1000_1414);

    // Same slow register on both ports: one bank read.
    bundle(5'd9, 5'd9, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    chk("t4_rdata_a", obs_a, 32'h9999_0009);
    chk("t4_rdata_b", obs_b, 32'h9999_0009);
    chk("t4_stall_cycles", obs_stall, 2);

    bundle(5'd10, 5'd3,  5'd0,  32'h0,      0, 32'h0,   32'h0,   3, 2);
    bundle(5'd13, 5'd3,  5'd13, 32'h5555,   1, 32'hF13, 32'h0,   1, 2);
    chk("fwd_fast_a", obs_a, 32'h5555);
    bundle(5'd0,  5'd14, 5'd0,  32'h77,     1, 32'h0,   32'hF14, 0, 1);
    chk("x0_a", obs_a, 32'h0);
    chk("fast_b", obs_b, 32'hF14);
    bundle(5'd9,  5'd9,  5'd9,  32'hCAFE,   1, 32'h0,   32'h0,   0, 1);
    bundle(5'd22, 5'd11, 5'd22, 32'h1111,   1, 32'h0,   32'h0,   2, 3);
    bundle(5'd22, 5'd15, 5'd0,  32'h0,      0, 32'h0,   32'hF15, 1, 1);
    chk("readback_22", obs_a, 32'h1111);
    bundle(5'd4,  5'd4,  5'd12, 32'h4242,   1, 32'h0,   32'h0,   0, 2);
    chk_perf("mid");

    // Grant withheld, then reset in the middle of the wait.
    @(posedge clk); #1;
    exp_ops.delete();
    op.we = 0; op.addr = 5'd6; op.data = 0; exp_ops.push_back(op);
    ra = 5'd6; rb = 5'd0; we = 1'b0; acc_valid = 1'b1; gd = 1000; rvd = 1; wcnt = 0;
    exp_fwe = 0; exp_left = 1000; first = 1; done = 0; active = 1;
    repeat (4) @(posedge clk);
    #3; active = 0; rst_ni = 1'b0;
    #1;
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_req", bif.bank_req_o, 1'b0);
    chk("midrst_addr", bif.bank_addr_o, 0);
    tot_stall = 0; tot_acc = 0;
    chk_perf("midrst");
    @(posedge clk); #1; acc_valid = 1'b0; rst_ni = 1'b1; exp_ops.delete();
    repeat (2) @(negedge clk);
    chk("postrst_stall", stall, 1'b0);
    chk("postrst_req", bif.bank_req_o, 1'b0);

    bundle(5'd6, 5'd0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    chk("recover_stall_cycles", obs_stall, 2);
    chk_perf("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ibex_rf_bank_sched.md
# ibex_rf_bank_sched

Access scheduler for the two-level register file: registers x12–x15 live in a fast multi-ported bank, all other non-zero registers in a slow single-ported bank. Per decoded instruction (up to two reads, one write), it serves fast-bank accesses immediately and serialises slow-bank accesses over a request/grant/rvalid handshake. While slow work is pending it raises a stall to the ID stage, then presents final operand data. It sits between the ID/WB stages and the two register banks.

## Interface
- DataWidth, 32, register width
- RV32E, 0, 1 = 16 architectural registers; addresses ≥16 treated as x0
- FastLo, 12, first fast-bank register
- FastHi, 15, last fast-bank register
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- acc_valid_i  in  1  access bundle valid; held stable while stall_o=1
- raddr_a_i / raddr_b_i  in  5  read addresses
- waddr_i  in  5  write address
- wdata_i  in  DataWidth  write data
- we_i  in  1  write enable
- stall_o  out  1  slow access pending; ID must hold
- rdata_a_o / rdata_b_o  out  DataWidth  final operand data, valid when acc_valid_i & !stall_o
- fast_we_o  out  1  fast-bank write strobe (uses waddr_i/wdata_i)
- fast_rdata_a_i / fast_rdata_b_i  in  DataWidth  fast-bank data for raddr_a_i/raddr_b_i
- bank_req_o  out  1  slow-bank request
- bank_we_o  out  1  request is a write
- bank_addr_o  out  5  slow-bank address
- bank_wdata_o  out  DataWidth  slow-bank write data
- bank_gnt_i  in  1  request accepted this cycle
- bank_rvalid_i  in  1  read data valid
- bank_rdata_i  in  DataWidth  read data
- perf_stall_cnt_o / perf_access_cnt_o  out  32  performance counters (see Configuration)

## Operation
- Classification per address: zero (x0 or out of range), fast (FastLo..FastHi), slow (other).
- Write zero: dropped. Write fast: fast_we_o = acc_valid_i & we_i & state IDLE; never stalls.
- Forwarding: a read whose address equals waddr_i with we_i=1 (non-zero) returns wdata_i and needs no bank read.
- raddr_a_i == raddr_b_i, both slow and not forwarded: a single bank read serves both ports.
- Slow ops in fixed order: WRITE, READ_A, READ_B; unneeded ops skipped.
- FSM: IDLE -> first needed op (or stays IDLE if none) -> … -> DONE -> IDLE.
  - WRITE: bank_req_o=1, bank_we_o=1 until bank_gnt_i; next op on grant.
  - READ_x: bank_req_o=1, bank_we_o=0 until grant, then wait bank_rvalid_i (no request); capture bank_rdata_i; next op.
  - DONE: one cycle; stall_o=0; captured data presented; bundle consumed, not re-evaluated.
- stall_o = (IDLE & acc_valid_i & any slow op) | state ∉ {IDLE, DONE}.
- rdata_x_o mux priority: zero -> 0; forward -> wdata_i; fast -> fast_rdata_x_i; slow -> captured register.
- Exactly one outstanding bank transaction; bank_rvalid_i outside READ wait state is ignored.
- Reset values: stall_o=0, bank_req_o=0, bank_we_o=0, bank_addr_o=0, bank_wdata_o=0, fast_we_o=0, captured data=0, state IDLE, counters 0.
- Reset mid-operation: immediate return to IDLE, bank_req_o drops asynchronously; outstanding bank data discarded.

## Timing
- No slow op: zero latency, data same cycle as acc_valid_i.
- Slow op cost: write = cycles to grant; read = cycles to grant + cycles grant->rvalid (≥1).
- Minimum stall with one slow read, grant in first cycle, rvalid next: stall_o high 2 cycles, DONE in cycle 3.
- Slow write + two distinct slow reads, zero-wait bank: stall 5 cycles.
- bank_req_o, bank_addr_o, bank_we_o, bank_wdata_o stable from assertion until grant.

## Configuration
- RF_BANK_SCHED_PERF_EN defined: perf_stall_cnt_o counts cycles with stall_o=1; perf_access_cnt_o counts bank grants; both saturate at 2^32-1, cleared by reset.
- Undefined: counters not built; both outputs tied to 0.

## Test plan
- raddr_a=12, raddr_b=0, no write, fast_rdata_a=0xA5A5 -> stall_o=0, rdata_a=0xA5A5, rdata_b=0, no bank_req_o.
- raddr_a=5, bank grants immediately, rvalid next cycle with 0x1234 -> stall_o 2 cycles, rdata_a_o=0x1234 in DONE.
- we=1 waddr=7 wdata=0xBEEF, raddr_a=7, raddr_b=20 -> bank write to 7, read of 20 only; rdata_a_o=0xBEEF.
- raddr_a=raddr_b=9 -> single bank read; both outputs equal returned data.
- Grant withheld 3 cycles on READ_A -> bank_req_o/addr stable; reset asserted mid-wait -> stall_o=0, bank_req_o=0 immediately.
- With RF_BANK_SCHED_PERF_EN, write+two slow reads zero-wait -> perf_access_cnt_o=3, perf_stall_cnt_o=5.
